// File: rtl/rv_div_seq.sv
// rv_div_seq: iterative RV32M divider (DIV, DIVU, REM, REMU) with no adder of
// its own. It drives the core's combinational ALU every cycle it needs
// arithmetic and consumes the ALU result in the same cycle. One restoring
// step takes a CMP cycle and a SUB cycle, so 32 quotient bits take 64 cycles.
`timescale 1ns/1ps

module rv_div_seq #(
   parameter bit         CMP_SKIP     = 1'b0,   // 1: skip SUB when rem < divisor
   // ALU control codes; keep these equal to the core's ALU decode.
   parameter logic [4:0] ALU_CTRL_ADD = 5'd0,
   parameter logic [4:0] ALU_CTRL_SUB = 5'd8,
   parameter logic [4:0] ALU_CMP_LTU  = 5'd3
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic        o_busy,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   output logic [4:0]  o_alu_ctrl,
   input  logic [31:0] i_alu_result
);

   typedef enum logic [2:0] {
      S_IDLE, S_NEG_A, S_NEG_B, S_CMP, S_SUB, S_FIX, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  op;          // op[1]: remainder wanted, op[0]: unsigned
   logic        a_neg, b_neg;
   logic [31:0] divisor;
   logic [31:0] rem;
   logic [31:0] quo;         // dividend bits shift out, quotient bits shift in
   logic        lt;
   logic [4:0]  cnt;

   // Decode of the incoming request, only meaningful in IDLE
   logic acc_signed, acc_a_neg, acc_b_neg, acc_div_zero, acc_ovf;
   assign acc_signed   = ~i_op[0];
   assign acc_a_neg    = acc_signed & i_dividend[31];
   assign acc_b_neg    = acc_signed & i_divisor[31];
   assign acc_div_zero = (i_divisor == 32'h0);
   assign acc_ovf      = acc_signed & (i_dividend == 32'h8000_0000) &
                         (i_divisor == 32'hFFFF_FFFF);

   // Restoring-division step terms. A set rem_msb means the shifted
   // candidate is really >= 2^32, so it is never below the divisor.
   logic [31:0] cand;
   logic        rem_msb, cmp_lt, last, need_fix;
   assign cand     = {rem[30:0], quo[31]};
   assign rem_msb  = rem[31];
   assign cmp_lt   = i_alu_result[0] & ~rem_msb;
   assign last     = (cnt == 5'd31);
   assign need_fix = op[1] ? a_neg : (a_neg ^ b_neg);

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the values from before the edge, independent of block order.
      if (!i_reset_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   // Next-state selection; flush overrides everything but reset
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned,
      // which would infer a latch.
      state_nxt = state;
      if (i_flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (i_valid) begin
                        if (acc_div_zero || acc_ovf) state_nxt = S_DONE;
                        else if (acc_a_neg)          state_nxt = S_NEG_A;
                        else if (acc_b_neg)          state_nxt = S_NEG_B;
                        else                         state_nxt = S_CMP;
                     end
            S_NEG_A: state_nxt = b_neg ? S_NEG_B : S_CMP;
            S_NEG_B: state_nxt = S_CMP;
            S_CMP:   if (CMP_SKIP && cmp_lt)
                        state_nxt = last ? (need_fix ? S_FIX : S_DONE) : S_CMP;
                     else
                        state_nxt = S_SUB;
            S_SUB:   state_nxt = last ? (need_fix ? S_FIX : S_DONE) : S_CMP;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  if (i_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath registers: operand capture, negation, shift/subtract, final fix
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         op      <= 2'b00;
         a_neg   <= 1'b0;
         b_neg   <= 1'b0;
         divisor <= 32'h0;
         rem     <= 32'h0;
         quo     <= 32'h0;
         lt      <= 1'b0;
         cnt     <= 5'd0;
      end else if (!i_flush) begin
         case (state)
            S_IDLE: if (i_valid) begin
               op      <= i_op;
               a_neg   <= acc_a_neg;
               b_neg   <= acc_b_neg;
               divisor <= i_divisor;
               lt      <= 1'b0;
               cnt     <= 5'd0;
               // Special cases load the final answer and skip the loop
               if (acc_div_zero) begin
                  quo <= 32'hFFFF_FFFF;
                  rem <= i_dividend;
               end else if (acc_ovf) begin
                  quo <= 32'h8000_0000;
                  rem <= 32'h0;
               end else begin
                  quo <= i_dividend;
                  rem <= 32'h0;
               end
            end
            S_NEG_A: quo     <= i_alu_result;
            S_NEG_B: divisor <= i_alu_result;
            S_CMP: begin
               lt <= cmp_lt;
               if (CMP_SKIP && cmp_lt) begin
                  rem <= cand;
                  quo <= {quo[30:0], 1'b0};
                  cnt <= cnt + 5'd1;
               end
            end
            S_SUB: begin
               rem <= lt ? cand : i_alu_result;
               quo <= {quo[30:0], ~lt};
               cnt <= cnt + 5'd1;
            end
            S_FIX: if (op[1]) rem <= i_alu_result;
                   else       quo <= i_alu_result;
            default: ;
         endcase
      end
   end

   // Outputs: handshake flags, result mux and ALU drive per state
   always_comb begin
      o_ready    = (state == S_IDLE);
      o_busy     = (state != S_IDLE);
      o_valid    = (state == S_DONE);
      o_result   = (state == S_DONE) ? (op[1] ? rem : quo) : 32'h0;
      o_alu_a    = 32'h0;
      o_alu_b    = 32'h0;
      o_alu_ctrl = ALU_CTRL_ADD;
      case (state)
         S_NEG_A: begin o_alu_b = quo;     o_alu_ctrl = ALU_CTRL_SUB; end
         S_NEG_B: begin o_alu_b = divisor; o_alu_ctrl = ALU_CTRL_SUB; end
         S_CMP:   begin
            o_alu_a    = cand;
            o_alu_b    = divisor;
            o_alu_ctrl = ALU_CMP_LTU;
         end
         S_SUB:   begin
            o_alu_a    = cand;
            o_alu_b    = divisor;
            o_alu_ctrl = ALU_CTRL_SUB;
         end
         S_FIX:   begin
            o_alu_b    = op[1] ? rem : quo;
            o_alu_ctrl = ALU_CTRL_SUB;
         end
         default: ;
      endcase
   end

endmodule
